// File: rtl/fp16_conv_arbiter_if.sv
// Bundle of requester lanes and the tagged fp16 result stream.
// The arbiter is the slave side; whoever drives the lanes and drains results is the master.
interface fp16_conv_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  out_valid;
    logic [15:0]           out_data;
    logic [ID_W-1:0]       out_id;
    logic                  out_ready;
    logic [15:0]           conv_count;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, conv_count
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, conv_count
    );
endinterface

// File: rtl/fp16_conv_arbiter.sv
// Round-robin arbiter with burst locking in front of one shared fp32->fp16 converter.
// The converted word is held in a single valid/ready output stage tagged with its source ID.

// Combinational fp32 -> fp16 conversion, round-to-nearest-even.
// Overflow goes to infinity, tiny values become fp16 subnormals or signed zero,
// NaNs stay NaN with the quiet bit forced and the upper payload bits kept.
module fp32_to_fp16 (
    input  logic [31:0] din,
    output logic [15:0] dout
);
    logic        sign;
    logic [7:0]  exp32;
    logic [22:0] man32;
    logic [4:0]  norm_exp;
    logic        norm_rnd;
    logic [3:0]  sub_sh;
    logic [35:0] sub_shifted;
    logic        sub_rnd;
    logic [14:0] mag;

    assign sign  = din[31];
    assign exp32 = din[30:23];
    assign man32 = din[22:0];

    // Normal range: rebias 127 -> 15, keep top 10 mantissa bits, round on bit 12.
    assign norm_exp = 5'(exp32 - 8'd112);
    assign norm_rnd = man32[12] & ((|man32[11:0]) | man32[13]);

    // Subnormal range: significand with hidden bit, pre-scaled so bits [35:26]
    // are the fp16 mantissa once shifted right by (112 - exp32).
    assign sub_sh      = 4'(8'd112 - exp32);
    assign sub_shifted = {1'b1, man32, 12'd0} >> sub_sh;
    assign sub_rnd     = sub_shifted[25] & ((|sub_shifted[24:0]) | sub_shifted[26]);

    // Select the magnitude by exponent range; a rounding carry naturally
    // bumps the exponent (including max-normal -> infinity).
    always_comb begin
        mag = 15'd0;
        if (exp32 == 8'hFF) begin
            mag = (man32 == '0) ? 15'h7C00 : {5'h1F, 1'b1, man32[21:13]};
        end else if (exp32 >= 8'd143) begin
            mag = 15'h7C00;
        end else if (exp32 >= 8'd113) begin
            mag = {norm_exp, man32[22:13]} + {14'd0, norm_rnd};
        end else if (exp32 >= 8'd101) begin
            mag = {5'd0, sub_shifted[35:26]} + {14'd0, sub_rnd};
        end
    end

    assign dout = {sign, mag};
endmodule

module fp16_conv_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    fp16_conv_arbiter_if.slave  bus
);
    localparam logic [0:0]      ST_ARB     = 1'b0;
    localparam logic [0:0]      ST_LOCK    = 1'b1;
    localparam logic [3:0]      BURST_W    = 4'(BURST_LEN);
    localparam logic [ID_W:0]   NUM_REQ_W  = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] NUM_REQ_LO = ID_W'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_REQ   = ID_W'(NUM_REQ - 1);

    logic [0:0]      state_reg, state_next;
    logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [3:0]      burst_cnt_reg, burst_cnt_next;

    logic            out_valid_reg;
    logic [15:0]     out_data_reg;
    logic [ID_W-1:0] out_id_reg;
    logic [15:0]     conv_count_reg;

    logic [31:0]        req_word [NUM_REQ];
    logic [ID_W-1:0]    scan_idx [NUM_REQ];
    logic [NUM_REQ-1:0] scan_valid;
    logic [NUM_REQ-1:0] ready_vec;

    logic            arb_found;
    logic [ID_W-1:0] arb_idx;
    logic [ID_W-1:0] grant_idx;
    logic            grant_valid;
    logic            can_load;
    logic            xfer;
    logic [15:0]     conv_out;

    // Per-requester word slices and the round-robin scan order rr_ptr+1, rr_ptr+2, ...
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            localparam logic [ID_W:0] OFS = (ID_W+1)'(gi + 1);
            logic [ID_W:0] scan_sum;

            assign req_word[gi]   = bus.req_data[32*gi +: 32];
            assign scan_sum       = {1'b0, rr_ptr_reg} + OFS;
            assign scan_idx[gi]   = (scan_sum >= NUM_REQ_W) ? (scan_sum[ID_W-1:0] - NUM_REQ_LO)
                                                            : scan_sum[ID_W-1:0];
            assign scan_valid[gi] = bus.req_valid[scan_idx[gi]];
            assign ready_vec[gi]  = xfer && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // Pick the first valid requester in scan order (lowest scan position wins).
    always_comb begin
        arb_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (scan_valid[k]) begin
                arb_idx = scan_idx[k];
            end
        end
    end

    assign arb_found   = |scan_valid;
    assign grant_idx   = (state_reg == ST_LOCK) ? rr_ptr_reg : arb_idx;
    assign grant_valid = (state_reg == ST_LOCK) ? bus.req_valid[rr_ptr_reg] : arb_found;
    assign can_load    = !out_valid_reg || bus.out_ready;
    // rst_n gates the accept so nothing is offered to requesters while in reset.
    assign xfer        = rst_n && can_load && grant_valid;

    assign bus.req_ready = ready_vec;

    fp32_to_fp16 u_conv (
        .din  (req_word[grant_idx]),
        .dout (conv_out)
    );

    // Arbitration FSM: free round-robin in ARB, fixed grant while a burst is locked.
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        burst_cnt_next = burst_cnt_reg;
        case (state_reg)
            ST_ARB: begin
                if (xfer) begin
                    rr_ptr_next    = arb_idx;
                    burst_cnt_next = 4'd1;
                    state_next     = (BURST_LEN > 1) ? ST_LOCK : ST_ARB;
                end
            end
            ST_LOCK: begin
                if (xfer) begin
                    burst_cnt_next = burst_cnt_reg + 4'd1;
                    if (burst_cnt_next == BURST_W) begin
                        state_next = ST_ARB;
                    end
                end else if (can_load) begin
                    // Locked requester went idle: take a bubble and release the lock.
                    state_next = ST_ARB;
                end
            end
            default: state_next = ST_ARB;
        endcase
    end

    // Arbiter state registers; reset gives requester 0 first priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_ARB;
            rr_ptr_reg    <= LAST_REQ;
            burst_cnt_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    // Output stage: load on accept (replacing any word drained this cycle), clear on drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= 16'd0;
            out_id_reg     <= '0;
            conv_count_reg <= 16'd0;
        end else if (xfer) begin
            out_valid_reg  <= 1'b1;
            out_data_reg   <= conv_out;
            out_id_reg     <= grant_idx;
            conv_count_reg <= conv_count_reg + 16'd1;
        end else if (out_valid_reg && bus.out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign bus.out_valid  = out_valid_reg;
    assign bus.out_data   = out_data_reg;
    assign bus.out_id     = out_id_reg;
    assign bus.conv_count = conv_count_reg;
endmodule

// File: tb/tb_fp16_conv_arbiter.sv
// Directed bench: a BURST_LEN=1 instance for conversion vectors and pure round-robin,
// and a BURST_LEN=4 instance driven from a per-cycle table for locking, stalls and reset.
module tb_fp16_conv_arbiter;
    logic clk = 1'b0;
    logic rst_n_rr;
    logic rst_n_bl;

    always #5 clk = ~clk;

    fp16_conv_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus_rr ();
    fp16_conv_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus_bl ();

    fp16_conv_arbiter #(.NUM_REQ(4), .ID_W(2), .BURST_LEN(1)) dut_rr (
        .clk   (clk),
        .rst_n (rst_n_rr),
        .bus   (bus_rr.slave)
    );

    fp16_conv_arbiter #(.NUM_REQ(4), .ID_W(2), .BURST_LEN(4)) dut_bl (
        .clk   (clk),
        .rst_n (rst_n_bl),
        .bus   (bus_bl.slave)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [1:0]  exp_id;
        logic [15:0] exp_data;
        logic [15:0] exp_cnt;
    } bl_vec_t;

    typedef struct {
        logic [1:0]  req;
        logic [31:0] fp32;
        logic [15:0] fp16;
    } cv_vec_t;

    bl_vec_t bl_q[$];
    cv_vec_t cv_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    endtask

    task automatic add_bl(input logic r, input logic [3:0] v, input logic o, input logic [3:0] er,
                          input logic eov, input logic [1:0] eid, input logic [15:0] ed, input logic [15:0] ec);
        bl_q.push_back('{r, v, o, er, eov, eid, ed, ec});
    endtask

    task automatic add_cv(input logic [1:0] r, input logic [31:0] f, input logic [15:0] h);
        cv_q.push_back('{r, f, h});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_rr();
        rst_n_rr = 1'b0;
        bus_rr.req_valid = 4'b0000;
        tick();
        rst_n_rr = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rst_n, valid, out_ready | req_ready, out_valid, out_id, out_data, conv_count (after edge)
        add_bl(0, 4'b1111, 1, 4'b0000, 0, 0, 16'h0000, 0);
        add_bl(1, 4'b1111, 1, 4'b0001, 1, 0, 16'h3C00, 1);
        add_bl(1, 4'b1111, 1, 4'b0001, 1, 0, 16'h3C00, 2);
        add_bl(1, 4'b1111, 1, 4'b0001, 1, 0, 16'h3C00, 3);
        add_bl(1, 4'b1111, 1, 4'b0001, 1, 0, 16'h3C00, 4);
        add_bl(1, 4'b1111, 1, 4'b0010, 1, 1, 16'hC000, 5);
        add_bl(1, 4'b1111, 1, 4'b0010, 1, 1, 16'hC000, 6);
        add_bl(1, 4'b1101, 1, 4'b0000, 0, 1, 16'hC000, 6);   // r1 drops: bubble
        add_bl(1, 4'b1111, 1, 4'b0100, 1, 2, 16'h7C00, 7);
        add_bl(1, 4'b1111, 0, 4'b0000, 1, 2, 16'h7C00, 7);   // 3-cycle stall
        add_bl(1, 4'b1111, 0, 4'b0000, 1, 2, 16'h7C00, 7);
        add_bl(1, 4'b1111, 0, 4'b0000, 1, 2, 16'h7C00, 7);
        add_bl(1, 4'b1111, 1, 4'b0100, 1, 2, 16'h7C00, 8);
        add_bl(1, 4'b1111, 1, 4'b0100, 1, 2, 16'h7C00, 9);
        add_bl(1, 4'b1111, 1, 4'b0100, 1, 2, 16'h7C00, 10);
        add_bl(1, 4'b1111, 1, 4'b1000, 1, 3, 16'h0400, 11);
        add_bl(1, 4'b1111, 1, 4'b1000, 1, 3, 16'h0400, 12);
        add_bl(0, 4'b1111, 0, 4'b0000, 0, 0, 16'h0000, 0);   // reset mid-burst, held word
        add_bl(1, 4'b1111, 1, 4'b0001, 1, 0, 16'h3C00, 1);
        add_bl(1, 4'b0000, 1, 4'b0000, 0, 0, 16'h3C00, 1);
        add_bl(1, 4'b0001, 1, 4'b0001, 1, 0, 16'h3C00, 2);   // scan wraps back to self
        add_bl(1, 4'b1110, 1, 4'b0000, 0, 0, 16'h3C00, 2);
        add_bl(1, 4'b1010, 0, 4'b0010, 1, 1, 16'hC000, 3);   // empty stage accepts despite out_ready=0
        add_bl(1, 4'b1010, 0, 4'b0000, 1, 1, 16'hC000, 3);
        add_bl(1, 4'b1010, 1, 4'b0010, 1, 1, 16'hC000, 4);   // drain and load together

        add_cv(0, 32'h3F800000, 16'h3C00);
        add_cv(1, 32'hC0000000, 16'hC000);
        add_cv(2, 32'h7F800000, 16'h7C00);
        add_cv(3, 32'h00000000, 16'h0000);
        add_cv(0, 32'h80000000, 16'h8000);
        add_cv(1, 32'h477FE000, 16'h7BFF);
        add_cv(2, 32'h47800000, 16'h7C00);
        add_cv(3, 32'h477FF000, 16'h7C00);
        add_cv(0, 32'h38800000, 16'h0400);
        add_cv(1, 32'h38000000, 16'h0200);
        add_cv(2, 32'h33800000, 16'h0001);
        add_cv(3, 32'h33000000, 16'h0000);
        add_cv(0, 32'h33000001, 16'h0001);
        add_cv(1, 32'h3F801000, 16'h3C00);
        add_cv(2, 32'h3F803000, 16'h3C02);
        add_cv(3, 32'h7FC00000, 16'h7E00);
        add_cv(0, 32'hC2C80000, 16'hD640);
        add_cv(1, 32'hFF800000, 16'hFC00);
        add_cv(2, 32'h33C00000, 16'h0002);

        rst_n_rr = 1'b0;
        rst_n_bl = 1'b0;
        bus_rr.req_valid = 4'b0000;
        bus_rr.req_data  = '0;
        bus_rr.out_ready = 1'b1;
        bus_bl.req_valid = 4'b1111;
        bus_bl.req_data  = {32'h38800000, 32'h7F800000, 32'hC0000000, 32'h3F800000};
        bus_bl.out_ready = 1'b1;

        // Reset state, with all requesters asserting valid.
        #1;
        check("reset_req_ready", 32'(bus_bl.req_ready), 32'h0);
        tick();
        check("reset_out_valid", 32'(bus_bl.out_valid), 32'h0);
        check("reset_out_data", 32'(bus_bl.out_data), 32'h0);
        check("reset_out_id", 32'(bus_bl.out_id), 32'h0);
        check("reset_conv_count", 32'(bus_bl.conv_count), 32'h0);

        // Single requester, 1.0 -> 0x3C00 with one cycle latency.
        rst_n_bl = 1'b1;
        bus_bl.req_valid = 4'b0001;
        #1;
        check("t1_req_ready", 32'(bus_bl.req_ready), 32'h1);
        tick();
        check("t1_out_valid", 32'(bus_bl.out_valid), 32'h1);
        check("t1_out_data", 32'(bus_bl.out_data), 32'h3C00);
        check("t1_out_id", 32'(bus_bl.out_id), 32'h0);
        check("t1_conv_count", 32'(bus_bl.conv_count), 32'h1);
        $display("t1: id=%0d data=%h count=%0d", bus_bl.out_id, bus_bl.out_data, bus_bl.conv_count);

        // Burst-lock table, one row per cycle.
        for (int i = 0; i < bl_q.size(); i++) begin
            rst_n_bl = bl_q[i].rst;
            bus_bl.req_valid = bl_q[i].valid;
            bus_bl.out_ready = bl_q[i].ordy;
            #1;
            check($sformatf("bl%0d_req_ready", i), 32'(bus_bl.req_ready), 32'(bl_q[i].exp_rdy));
            tick();
            check($sformatf("bl%0d_out_valid", i), 32'(bus_bl.out_valid), 32'(bl_q[i].exp_ov));
            check($sformatf("bl%0d_out_id", i), 32'(bus_bl.out_id), 32'(bl_q[i].exp_id));
            check($sformatf("bl%0d_out_data", i), 32'(bus_bl.out_data), 32'(bl_q[i].exp_data));
            check($sformatf("bl%0d_conv_count", i), 32'(bus_bl.conv_count), 32'(bl_q[i].exp_cnt));
            $display("bl row %0d: rst_n=%b valid=%b out_ready=%b -> valid=%b id=%0d data=%h count=%0d",
                     i, bl_q[i].rst, bl_q[i].valid, bl_q[i].ordy,
                     bus_bl.out_valid, bus_bl.out_id, bus_bl.out_data, bus_bl.conv_count);
        end
        bus_bl.req_valid = 4'b0000;

        // Pure round-robin with every requester valid: ids 0,1,2,3,0.
        reset_rr();
        bus_rr.req_data  = {32'h38800000, 32'h7F800000, 32'h3F800000, 32'hC0000000};
        bus_rr.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [15:0] exp_word [4];
            exp_word[0] = 16'hC000;
            exp_word[1] = 16'h3C00;
            exp_word[2] = 16'h7C00;
            exp_word[3] = 16'h0400;
            #1;
            check($sformatf("rr%0d_req_ready", k), 32'(bus_rr.req_ready), 32'(1 << (k % 4)));
            tick();
            check($sformatf("rr%0d_out_id", k), 32'(bus_rr.out_id), 32'(k % 4));
            check($sformatf("rr%0d_out_data", k), 32'(bus_rr.out_data), 32'(exp_word[k % 4]));
            check($sformatf("rr%0d_conv_count", k), 32'(bus_rr.conv_count), 32'(k + 1));
            $display("rr %0d: id=%0d data=%h count=%0d", k, bus_rr.out_id, bus_rr.out_data, bus_rr.conv_count);
        end

        // Conversion vectors, one requester valid per cycle.
        reset_rr();
        for (int i = 0; i < cv_q.size(); i++) begin
            bus_rr.req_data  = 128'(cv_q[i].fp32) << (32 * cv_q[i].req);
            bus_rr.req_valid = 4'(1 << cv_q[i].req);
            #1;
            check($sformatf("cv%0d_req_ready", i), 32'(bus_rr.req_ready), 32'(1 << cv_q[i].req));
            tick();
            check($sformatf("cv%0d_out_data", i), 32'(bus_rr.out_data), 32'(cv_q[i].fp16));
            check($sformatf("cv%0d_out_id", i), 32'(bus_rr.out_id), 32'(cv_q[i].req));
            check($sformatf("cv%0d_conv_count", i), 32'(bus_rr.conv_count), 32'(i + 1));
            $display("cv %0d: req=%0d in=%h -> out=%h", i, cv_q[i].req, cv_q[i].fp32, bus_rr.out_data);
        end
        bus_rr.req_valid = 4'b0000;
        tick();
        check("cv_drain_out_valid", 32'(bus_rr.out_valid), 32'h0);

        // conv_count wrap after 65536 transfers.
        reset_rr();
        bus_rr.req_data  = {96'd0, 32'h3F800000};
        bus_rr.req_valid = 4'b0001;
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_count_ffff", 32'(bus_rr.conv_count), 32'hFFFF);
        tick();
        check("wrap_count_zero", 32'(bus_rr.conv_count), 32'h0);
        check("wrap_out_valid", 32'(bus_rr.out_valid), 32'h1);
        check("wrap_out_data", 32'(bus_rr.out_data), 32'h3C00);
        check("wrap_out_id", 32'(bus_rr.out_id), 32'h0);
        $display("wrap: count=%h data=%h", bus_rr.conv_count, bus_rr.out_data);
        bus_rr.req_valid = 4'b0000;
        tick();
        check("wrap_idle_count", 32'(bus_rr.conv_count), 32'h0);
        check("wrap_idle_out_valid", 32'(bus_rr.out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/fp16_conv_arbiter.md
Name: fp16_conv_arbiter

Overview:
- Shares one fp32_to_fp16 converter instance among NUM_REQ streaming requesters.
- Uses round-robin arbitration with optional burst locking, so one requester can keep the grant for up to BURST_LEN consecutive words.
- Registers each converted result in a single output stage with valid/ready backpressure, tagged with the source requester ID.
- Sits between the DSP slice input lanes and the half-precision writeback path.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
BURST_LEN, 4, maximum consecutive grants to one requester (1..15); 1 means pure round-robin.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  NUM_REQ  per-requester word valid
req_data  input  32*NUM_REQ  fp32 words; requester i occupies bits [32i+31:32i]
req_ready  output  NUM_REQ  one-hot (or zero) accept strobe per requester
out_valid  output  1  converted result valid
out_data  output  16  fp16 result
out_id  output  ID_W  requester index of out_data
out_ready  input  1  downstream accept
conv_count  output  16  total accepted conversions, wraps at 0xFFFF->0

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - out_valid=0, out_data=0, out_id=0, conv_count=0.
  - Round-robin pointer rr_ptr=NUM_REQ-1, so requester 0 has top priority first.
  - FSM in ARB; burst counter=0.
  - req_ready is combinational and therefore 0 during reset.
- Reset mid-operation discards any held output word without handshake. Any in-flight burst is abandoned.
- can_load = !out_valid || out_ready.
- req_ready is all zeros when can_load=0. Otherwise at most one bit is set, for the granted requester, and only if that requester's req_valid is 1.
- Transfer occurs on a cycle where req_valid[g] && req_ready[g]. On that clock edge:
  - out_data <= fp32_to_fp16(req_data[g]).
  - out_id <= g; out_valid <= 1; conv_count += 1.
- If out_valid && out_ready with no new transfer, out_valid <= 0 at that edge.
- Latency is 1 cycle from accept to out_valid. Throughput is 1 word/cycle when out_ready is held high.
- Converter is combinational between the grant mux and the output register. No arithmetic is done in this block beyond the mux.
- FSM has two states:
  - ARB:
    - Grant g = first requester with req_valid=1, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
    - On transfer: rr_ptr <= g; burst counter <= 1; go to LOCK if BURST_LEN>1, else stay in ARB.
  - LOCK:
    - Grant is fixed to rr_ptr; other requesters are ignored even if valid.
    - On transfer: burst counter += 1. When the counter reaches BURST_LEN, return to ARB.
    - If req_valid[rr_ptr]=0 while can_load=1, return to ARB the next cycle with no transfer. That is a one-cycle bubble, and the lock is released.
    - If can_load=0, hold state and counter; the stall does not release the lock.
- Pointer wrap: scanning past NUM_REQ-1 wraps to 0.
- Simultaneous events:
  - Output drain and new load in the same cycle: the new word replaces the old one and out_valid stays 1.
  - conv_count wraps silently.
- Stability: req_data and req_valid are not required to be stable when not accepted. The arbiter re-evaluates every cycle in ARB.

Test Plan:
1. Reset, then req_valid=4'b0001, req_data[0]=0x3F800000, out_ready=1 → req_ready=4'b0001. Next cycle out_valid=1, out_data=0x3C00, out_id=0, conv_count=1.
2. BURST_LEN=1, all four requesters valid continuously (r0 = 0xC0000000), out_ready=1 → out_id sequence 0,1,2,3,0; r0 results = 0xC000; conv_count increments 5.
3. BURST_LEN=4, all valid → out_id 0,0,0,0,1,1,1,1. Drop req_valid[1] after two words → one bubble cycle, then grant moves to 2.
4. out_ready=0 for 3 cycles with out_valid=1 (data 0x7F800000 → 0x7C00) → req_ready=0 and out_data/out_id held. Release → accepts resume and the lock count is unchanged.
5. Assert rst_n=0 for one cycle mid-burst with out_valid=1 → next cycle out_valid=0, conv_count=0, next grant goes to requester 0.
6. Preload conv_count to 0xFFFF by 65535 transfers plus one → conv_count=0x0000, no other side effect.
